// File: rtl/sha_job_sequencer_pkg.sv
// Shared definitions for the SHA job sequencer and the accelerator register file:
// register offsets, control/status bit positions, core bases and FSM states.
package sha_job_sequencer_pkg;

   localparam logic [9:0] CORE0_BASE       = 10'h000;
   localparam logic [9:0] CORE1_BASE_DEF   = 10'h200;

   localparam logic [9:0] OFF_CONTROL      = 10'h000;
   localparam logic [9:0] OFF_MSG          = 10'h004;
   localparam logic [9:0] OFF_STATE_IN     = 10'h044;
   localparam logic [9:0] OFF_STATE_OUT    = 10'h064;
   localparam logic [9:0] OFF_STATUS       = 10'h084;

   localparam int GO_BIT   = 0;
   localparam int DONE_BIT = 31;
   localparam int OVF_BIT  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_MSG,
      ST_WR_STATE,
      ST_WR_GO,
      ST_POLL,
      ST_RD_OUT,
      ST_RD_STAT,
      ST_FINISH
   } seq_state_e;

   typedef enum logic [2:0] {
      REG_CONTROL,
      REG_MSG,
      REG_STATE_IN,
      REG_STATE_OUT,
      REG_STATUS
   } reg_region_e;

   function automatic logic [9:0] region_offset(input reg_region_e region);
      logic [9:0] off;
      case (region)
         REG_CONTROL:   off = OFF_CONTROL;
         REG_MSG:       off = OFF_MSG;
         REG_STATE_IN:  off = OFF_STATE_IN;
         REG_STATE_OUT: off = OFF_STATE_OUT;
         REG_STATUS:    off = OFF_STATUS;
         default:       off = OFF_CONTROL;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/sha_job_sequencer_if.sv
// Register-file bus between the job sequencer (master) and the accelerator
// register file (slave). Read data is combinational in the strobe cycle.
interface sha_job_sequencer_if;

   logic [9:0]  wb_addr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic        wb_re_o;

   modport master (
      output wb_addr_o,
      output wb_dat_o,
      output wb_we_o,
      output wb_re_o,
      input  wb_dat_i
   );

   modport slave (
      input  wb_addr_o,
      input  wb_dat_o,
      input  wb_we_o,
      input  wb_re_o,
      output wb_dat_i
   );

endinterface

// File: rtl/sha_bus_addr_gen.sv
// Register-file byte address = core base + region offset + 4 * word index.
module sha_bus_addr_gen
   import sha_job_sequencer_pkg::*;
(
   input  logic [9:0]  core_base,
   input  reg_region_e region,
   input  logic [3:0]  word_idx,
   output logic [9:0]  addr
);

   // Pure address arithmetic; the caller forces the index to 0 for single registers.
   always_comb begin
      addr = core_base + region_offset(region) + {4'b0000, word_idx, 2'b00};
   end

endmodule

// File: rtl/sha_job_sequencer.sv
// Sequences one SHA-256 block job on an accelerator core: loads message and chaining
// state, starts the core, polls DONE with a bounded budget and reads back the digest.
module sha_job_sequencer
   import sha_job_sequencer_pkg::*;
#(
   parameter int         POLL_LIMIT = 1024,
   parameter logic [9:0] CORE1_BASE = CORE1_BASE_DEF
) (
   input  logic               clk,
   input  logic               wb_rst_i,
   input  logic               start,
   input  logic               core_sel,
   input  logic [31:0]        msg_in [0:15],
   input  logic [31:0]        hash_in [0:7],
   output logic               busy,
   output logic               result_valid,
   output logic [31:0]        digest [0:7],
   output logic               overflow_o,
   output logic               timeout_o,
   sha_job_sequencer_if.master bus
);

   localparam int             PW       = $clog2(POLL_LIMIT + 1);
   localparam logic [PW-1:0]  POLL_MAX = PW'(POLL_LIMIT);

   seq_state_e    state_r, state_next;
   logic [3:0]    word_r, word_next;
   logic [PW-1:0] poll_r, poll_next, poll_inc_s;
   logic [31:0]   msg_r [0:15];
   logic [31:0]   hash_r [0:7];
   logic          core_sel_r;

   logic          capture_s, digest_we_s, ovf_we_s, timeout_set_s;
   reg_region_e   region_s;
   logic [3:0]    idx_s;
   logic          we_next_s, re_next_s, core_next_s;
   logic [31:0]   dat_next_s;
   logic [9:0]    core_base_s, addr_gen_s, addr_next_s;

   // Next-state, counters and capture/update enables.
   always_comb begin
      state_next    = state_r;
      word_next     = word_r;
      poll_next     = poll_r;
      capture_s     = 1'b0;
      digest_we_s   = 1'b0;
      ovf_we_s      = 1'b0;
      timeout_set_s = 1'b0;
      poll_inc_s    = (poll_r < POLL_MAX) ? poll_r + PW'(1) : poll_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_WR_MSG;
               word_next  = 4'd0;
               poll_next  = '0;
               capture_s  = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_WR_MSG: begin
            if (word_r == 4'd15) begin
               state_next = ST_WR_STATE;
               word_next  = 4'd0;
            end else begin
               word_next  = word_r + 4'd1;
            end
         end
         ST_WR_STATE: begin
            if (word_r == 4'd7) begin
               state_next = ST_WR_GO;
               word_next  = 4'd0;
            end else begin
               word_next  = word_r + 4'd1;
            end
         end
         ST_WR_GO: begin
            state_next = ST_POLL;
            poll_next  = '0;
         end
         ST_POLL: begin
            poll_next = poll_inc_s;
            if (bus.wb_dat_i[DONE_BIT]) begin
               state_next = ST_RD_OUT;
               word_next  = 4'd0;
            end else if (poll_inc_s == POLL_MAX) begin
               state_next    = ST_FINISH;
               timeout_set_s = 1'b1;
            end else begin
               state_next = ST_POLL;
            end
         end
         ST_RD_OUT: begin
            digest_we_s = 1'b1;
            if (word_r == 4'd7) begin
               state_next = ST_RD_STAT;
               word_next  = 4'd0;
            end else begin
               word_next  = word_r + 4'd1;
            end
         end
         ST_RD_STAT: begin
            ovf_we_s   = 1'b1;
            state_next = ST_FINISH;
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Bus cycle for the coming state; registered so the strobes are glitch-free.
   // An accepted start uses the live inputs because they are captured on the same edge.
   always_comb begin
      region_s    = REG_CONTROL;
      idx_s       = 4'd0;
      we_next_s   = 1'b0;
      re_next_s   = 1'b0;
      dat_next_s  = 32'h0000_0000;
      core_next_s = capture_s ? core_sel : core_sel_r;
      case (state_next)
         ST_WR_MSG: begin
            region_s   = REG_MSG;
            idx_s      = word_next;
            we_next_s  = 1'b1;
            dat_next_s = capture_s ? msg_in[0] : msg_r[word_next];
         end
         ST_WR_STATE: begin
            region_s   = REG_STATE_IN;
            idx_s      = word_next;
            we_next_s  = 1'b1;
            dat_next_s = hash_r[word_next[2:0]];
         end
         ST_WR_GO: begin
            we_next_s  = 1'b1;
            dat_next_s = 32'h0000_0001 << GO_BIT;
         end
         ST_POLL: begin
            re_next_s = 1'b1;
         end
         ST_RD_OUT: begin
            region_s  = REG_STATE_OUT;
            idx_s     = word_next;
            re_next_s = 1'b1;
         end
         ST_RD_STAT: begin
            region_s  = REG_STATUS;
            re_next_s = 1'b1;
         end
         ST_FINISH: begin
            // A timed-out job clears GO so the core is left idle.
            if (timeout_set_s) begin
               we_next_s = 1'b1;
            end else begin
               we_next_s = 1'b0;
            end
         end
         default: begin
            we_next_s = 1'b0;
         end
      endcase
      core_base_s = core_next_s ? CORE1_BASE : CORE0_BASE;
      addr_next_s = (we_next_s || re_next_s) ? addr_gen_s : 10'h000;
   end

   sha_bus_addr_gen u_addr_gen (
      .core_base (core_base_s),
      .region    (region_s),
      .word_idx  (idx_s),
      .addr      (addr_gen_s)
   );

   // State, captured job, result registers and registered bus outputs.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r       <= ST_IDLE;
         word_r        <= 4'd0;
         poll_r        <= '0;
         core_sel_r    <= 1'b0;
         busy          <= 1'b0;
         result_valid  <= 1'b0;
         overflow_o    <= 1'b0;
         timeout_o     <= 1'b0;
         bus.wb_addr_o <= 10'h000;
         bus.wb_dat_o  <= 32'h0000_0000;
         bus.wb_we_o   <= 1'b0;
         bus.wb_re_o   <= 1'b0;
         for (int i = 0; i < 16; i++) msg_r[i] <= 32'h0000_0000;
         for (int i = 0; i < 8; i++) begin
            hash_r[i] <= 32'h0000_0000;
            digest[i] <= 32'h0000_0000;
         end
      end else begin
         state_r       <= state_next;
         word_r        <= word_next;
         poll_r        <= poll_next;
         busy          <= (state_next != ST_IDLE);
         result_valid  <= (state_next == ST_FINISH);
         bus.wb_addr_o <= addr_next_s;
         bus.wb_dat_o  <= dat_next_s;
         bus.wb_we_o   <= we_next_s;
         bus.wb_re_o   <= re_next_s;
         if (capture_s) begin
            msg_r      <= msg_in;
            hash_r     <= hash_in;
            core_sel_r <= core_sel;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
         end else begin
            if (ovf_we_s) overflow_o <= bus.wb_dat_i[OVF_BIT];
            if (timeout_set_s) timeout_o <= 1'b1;
         end
         if (digest_we_s) digest[word_r[2:0]] <= bus.wb_dat_i;
      end
   end

endmodule

// File: doc/sha_job_sequencer.md
SHA_JOB_SEQUENCER -- requirements
Module: sha_job_sequencer

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 1024: maximum number of DONE-poll reads before the job times out.
REQ-002 SHALL have parameter CORE1_BASE, default 10'h200: address base of accelerator core 1 (core 0 base is 10'h000).
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 SHALL have port core_sel, input, 1 bit: target core, 0 or 1.
REQ-007 SHALL have port msg_in, input, 32 bits x [0:15]: 512-bit message block.
REQ-008 SHALL have port hash_in, input, 32 bits x [0:7]: chaining state.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port result_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port digest, output, 32 bits x [0:7]: hash result.
REQ-012 SHALL have port overflow_o, output, 1 bit: status bit0 captured for the last job.
REQ-013 SHALL have port timeout_o, output, 1 bit: last job hit POLL_LIMIT.
REQ-014 SHALL have port wb_addr_o, output, 10 bits: register-file byte address.
REQ-015 SHALL have port wb_dat_o, output, 32 bits: write data.
REQ-016 SHALL have port wb_dat_i, input, 32 bits: read data, combinational, valid in the same cycle as wb_re_o.
REQ-017 SHALL have ports wb_we_o and wb_re_o, outputs, 1 bit each: single-cycle write and read strobes, never both high.

Function
REQ-018 Register map SHALL be offsets from the core base: CONTROL 0x00 (bit0 GO, bit31 DONE), MSG[i] 0x04+4i, STATE_IN[i] 0x44+4i, STATE_OUT[i] 0x64+4i, STATUS 0x84.
REQ-019 FSM states SHALL be IDLE, WR_MSG, WR_STATE, WR_GO, POLL, RD_OUT, RD_STAT, FINISH.
REQ-020 In IDLE with start=1, the block SHALL capture msg_in, hash_in and core_sel, clear overflow_o and timeout_o, and go to WR_MSG.
REQ-021 WR_MSG SHALL issue 16 consecutive one-cycle writes, MSG[0] to MSG[15], then go to WR_STATE.
REQ-022 WR_STATE SHALL issue 8 writes, STATE_IN[0] to STATE_IN[7], then go to WR_GO.
REQ-023 WR_GO SHALL issue one write of 32'h1 to CONTROL, then go to POLL.
REQ-024 POLL SHALL issue one CONTROL read per cycle and count polls.
REQ-025 In POLL, when wb_dat_i[31]=1 the FSM SHALL go to RD_OUT.
REQ-026 In POLL, when the poll count reaches POLL_LIMIT with DONE still 0, the block SHALL write 32'h0 to CONTROL, set timeout_o, and go to FINISH; digest SHALL keep its prior value.
REQ-027 RD_OUT SHALL read STATE_OUT[0..7] into digest[0..7] in 8 cycles, then go to RD_STAT.
REQ-028 RD_STAT SHALL read STATUS, capture bit0 into overflow_o, and go to FINISH.
REQ-029 FINISH SHALL pulse result_valid for exactly one cycle, then return to IDLE.
REQ-030 With DONE seen on the first poll: bus activity SHALL start in cycle 1 after start is accepted, the first poll read SHALL occur in cycle 26, and result_valid SHALL assert in cycle 36.
REQ-031 start while busy=1 SHALL be ignored; no queuing.
REQ-032 Captured job inputs SHALL be stable for the whole job regardless of changes on the input ports.
REQ-033 The poll counter SHALL saturate and SHALL NOT wrap.
REQ-034 When idle, the bus outputs SHALL be addr=0, dat=0, we=0, re=0.
REQ-035 digest, overflow_o and timeout_o SHALL hold their values until the next accepted start.

Reset
REQ-036 On wb_rst_i the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-037 On wb_rst_i all outputs SHALL go to 0: busy, result_valid, digest, overflow_o, timeout_o and all bus outputs.
REQ-038 Reset mid-job SHALL abort immediately with no further bus cycles and no result_valid pulse.

Structure
REQ-039 A shared package SHALL hold the register offsets, the GO/DONE bit indices, the CORE1_BASE default and the FSM state enum, shared with the register-file block.
REQ-040 One sub-module, sha_bus_addr_gen, SHALL compute wb_addr_o from core base, region and word index.

Verification
REQ-041 Job to core 0 with msg_in[i]=i, hash_in = SHA-256 IV, model asserts DONE at the 3rd poll and returns STATE_OUT[i]=32'hA0+i -> 16+8 writes in order, GO write 0x00=32'h1, 3 polls, digest[i]=32'hA0+i, result_valid in cycle 38.
REQ-042 Job with core_sel=1 -> every address is 0x200+offset, first write to 0x204, GO write to 0x200.
REQ-043 Model never sets DONE, POLL_LIMIT=4 -> 4 polls, then write of 32'h0 to 0x00, timeout_o=1, one result_valid pulse, digest unchanged.
REQ-044 STATUS returns 32'h1 -> overflow_o=1 after the job; next start clears it to 0.
REQ-045 start pulsed in WR_STATE, then wb_rst_i asserted in POLL -> second start ignored, all outputs 0, no result_valid pulse; a fresh job afterwards completes normally.
